// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI-Lite response codes and default bus widths
package axil_pkg;

    localparam int AXIL_DATA_WIDTH = 32;
    localparam int AXIL_ADDR_WIDTH = 5;
    localparam int AXIL_NUM_REGS   = 6;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axil_resp_e;

endpackage

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - register storage with byte-strobed write port and registered read port
module axil_reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 6,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    input  logic                    rd_en_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_sel;

    // Indices with no matching register read as zero and write nothing.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_sel = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (rd_en_i) begin
                rd_data_q <= rd_sel;
            end
            if (wr_en_i) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_idx_i == IDX_W'(i) && wr_strb_i[b]) begin
                            regs_q[i][8*b +: 8] <= wr_data_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axil_reg_responder.sv
// rtl/axil_reg_responder.sv - AXI-Lite slave front end for a small byte-strobed register bank
module axil_reg_responder
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
    parameter int ADDR_WIDTH = AXIL_ADDR_WIDTH,
    parameter int NUM_REGS   = AXIL_NUM_REGS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
    endfunction

    logic              aw_held_q, aw_held_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    axil_resp_e        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    axil_resp_e        rresp_q, rresp_d;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]  ar_idx;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    // Readies come only from registered state, never from the valids.
    assign awready = !aw_held_q && !bvalid_q;
    assign wready  = !w_held_q && !bvalid_q;
    assign arready = !rvalid_q;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = aw_held_q && w_held_q;
    assign ar_idx = araddr[ADDR_WIDTH-1:2];

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = idx_in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = idx_in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    // Out-of-range indices match no storage, so the bank returns zero for them.
    axil_reg_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (commit),
        .wr_idx_i (aw_idx_q),
        .wr_data_i(wdata_q),
        .wr_strb_i(wstrb_q),
        .rd_en_i  (ar_hs),
        .rd_idx_i (ar_idx),
        .rd_data_o(rdata)
    );

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rresp_q;

endmodule

// File: tb/tb_axil_reg_responder.sv
// tb/tb_axil_reg_responder.sv - self-checking bench for axil_reg_responder
module tb_axil_reg_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [4:0]  awaddr = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [4:0]  araddr = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [31:0] model [6];

    always #5 clk = ~clk;

    axil_reg_responder dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [4:0] a);
        return (int'(a) / 4 < 6) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        return (int'(a) / 4 < 6) ? model[int'(a) / 4] : 32'h0;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a) / 4;
        if (idx < 6) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // mode 0: AW and W together, 1: AW first, 2: W first. Leaves bvalid pending.
    task automatic write_issue(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = (mode != 2); wvalid = (mode != 1);
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1; n++;
            if (aw_hs) begin aw_done = 1; awvalid = 0; end
            if (w_hs)  begin w_done = 1;  wvalid = 0;  end
            if (aw_done && !w_done) wvalid = 1;
            if (w_done && !aw_done) awvalid = 1;
        end
        awvalid = 0; wvalid = 0;
        check("w_handshakes", {aw_done, w_done}, 2'b11);
        n = 0;
        while (!bvalid && n < 10) begin @(posedge clk); #1; n++; end
        check("b_latency", n, 1);
        check("bresp", bresp, exp_resp(a));
        model_write(a, d, s);
    endtask

    task automatic b_accept(input int hold);
        logic [1:0] r0 = bresp;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("b_hold_bvalid", bvalid, 1);
            check("b_hold_bresp", bresp, r0);
            check("b_hold_awready", awready, 0);
            check("b_hold_wready", wready, 0);
            check("b_hold_arready", arready, !rvalid);
        end
        bready = 1; @(posedge clk); #1; bready = 0;
        check("b_done_bvalid", bvalid, 0);
        check("b_done_awready", awready, 1);
    endtask

    task automatic read_issue(input logic [4:0] a);
        araddr = a; arvalid = 1;
        check("arready", arready, 1);
        @(posedge clk); #1; arvalid = 0;
        check("r_latency", rvalid, 1);
        check("rdata", rdata, exp_rdata(a));
        check("rresp", rresp, exp_resp(a));
    endtask

    task automatic r_accept(input int hold);
        logic [31:0] d0 = rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("r_hold_rvalid", rvalid, 1);
            check("r_hold_rdata", rdata, d0);
            check("r_hold_arready", arready, 0);
        end
        rready = 1; @(posedge clk); #1; rready = 0;
        check("r_done_rvalid", rvalid, 0);
        check("r_done_arready", arready, 1);
    endtask

    initial begin
        logic [4:0]  a;
        logic [31:0] d, old0;
        foreach (model[i]) model[i] = '0;

        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        reset = 1;
        @(posedge clk); #1;
        check("rel_awready", awready, 1);
        check("rel_wready", wready, 1);
        check("rel_arready", arready, 1);

        // AW leads W; then read back
        write_issue(5'h04, 32'hDEADBEEF, 4'hF, 1); b_accept(0);
        read_issue(5'h04); r_accept(0);

        // partial strobe merge
        write_issue(5'h08, 32'h11223344, 4'hF, 0); b_accept(0);
        write_issue(5'h08, 32'hAABBCCDD, 4'h5, 2); b_accept(0);
        read_issue(5'h08);
        check("strb_merge", rdata, 32'h11BB33DD);
        r_accept(0);

        // out-of-range write and read
        write_issue(5'h18, 32'hFFFFFFFF, 4'hF, 0);
        check("oor_bresp", bresp, 2'b10);
        b_accept(0);
        for (int i = 0; i < 6; i++) begin read_issue(5'(i * 4)); r_accept(0); end
        read_issue(5'h1C);
        check("oor_rdata", rdata, 0);
        check("oor_rresp", rresp, 2'b10);
        r_accept(0);

        // write-response backpressure, with a read served meanwhile
        write_issue(5'h0C, 32'h0BADF00D, 4'hF, 0);
        b_accept(2);
        write_issue(5'h10, 32'h12345678, 4'hF, 1);
        read_issue(5'h0C); r_accept(0);
        check("b_after_read_bvalid", bvalid, 1);
        b_accept(5);

        // read backpressure
        read_issue(5'h10); r_accept(4);

        // read captured on the edge a write to the same register commits
        write_issue(5'h00, 32'hCAFEF00D, 4'hF, 0); b_accept(0);
        old0 = model[0];
        awaddr = 5'h00; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        araddr = 5'h00; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        check("coinc_bvalid", bvalid, 1);
        check("coinc_rvalid", rvalid, 1);
        check("coinc_old_value", rdata, old0);
        model_write(5'h00, 32'h5A5A5A5A, 4'hF);
        r_accept(0); b_accept(0);
        read_issue(5'h00); r_accept(0);

        // randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                write_issue(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
                b_accept(int'($urandom_range(0, 2)));
            end else begin
                read_issue(a);
                r_accept(int'($urandom_range(0, 2)));
            end
        end

        // reset with both responses pending
        write_issue(5'h04, 32'h77777777, 4'hF, 0);
        read_issue(5'h08);
        check("pre_rst_bvalid", bvalid, 1);
        reset = 0;
        @(posedge clk); #1;
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_bresp", bresp, 0);
        check("mid_rst_rresp", rresp, 0);
        reset = 1;
        @(posedge clk); #1;
        check("post_rst_awready", awready, 1);
        check("post_rst_wready", wready, 1);
        check("post_rst_arready", arready, 1);
        foreach (model[i]) model[i] = '0;
        for (int i = 0; i < 6; i++) begin
            read_issue(5'(i * 4));
            check("post_rst_zero", rdata, 0);
            r_accept(0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axil_reg_responder.md
AXIL_REG_RESPONDER -- requirements
Module: axil_reg_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (fixed to 32 in this revision).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, byte address width.
REQ-003 SHALL have parameter NUM_REGS, default 6, number of implemented 32-bit registers.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports awvalid input 1, awready output 1, awaddr input ADDR_WIDTH: write-address channel.
REQ-007 SHALL have ports wvalid input 1, wready output 1, wdata input DATA_WIDTH, wstrb input DATA_WIDTH/8: write-data channel.
REQ-008 SHALL have ports bvalid output 1, bready input 1, bresp output 2: write-response channel.
REQ-009 SHALL have ports arvalid input 1, arready output 1, araddr input ADDR_WIDTH: read-address channel.
REQ-010 SHALL have ports rvalid output 1, rready input 1, rdata output DATA_WIDTH, rresp output 2: read-data channel.

Function
REQ-011 SHALL decode register index as addr[ADDR_WIDTH-1:2]; addr[1:0] ignored; index >= NUM_REGS is out of range.
REQ-012 SHALL drive awready = !aw_held && !bvalid and wready = !w_held && !bvalid; AW and W accepted independently, in either order or the same cycle.
REQ-013 SHALL capture awaddr / wdata+wstrb into holding registers on their respective valid&&ready edges.
REQ-014 SHALL, on the edge after both holds are set, write in-range registers byte-wise per wstrb, clear both holds, set bvalid.
REQ-015 SHALL return bresp 2'b00 (OKAY) in range, 2'b10 (SLVERR) out of range; out-of-range writes modify no register.
REQ-016 SHALL hold bvalid and bresp stable until the bvalid&&bready edge, then clear bvalid.
REQ-017 SHALL drive arready = !rvalid (one outstanding read).
REQ-018 SHALL, on an arvalid&&arready edge, register rdata and rresp and set rvalid on that edge (one-cycle latency).
REQ-019 SHALL return rdata = register value with rresp OKAY in range; rdata = 0 with rresp SLVERR out of range.
REQ-020 SHALL hold rvalid, rdata and rresp stable until the rvalid&&rready edge.
REQ-021 SHALL, when read capture and write commit to the same register coincide on one edge, return the pre-write value.
REQ-022 SHALL operate the read and write paths fully independently; backpressure on one never stalls the other.
REQ-023 SHALL never depend combinationally on any *valid input through any *ready output.

Reset
REQ-024 SHALL, while reset is low at an edge, clear all registers to 0, clear aw_held/w_held, and drive bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-025 SHALL discard in-flight transactions on reset mid-operation; awready, wready and arready SHALL be 1 on the first cycle after release.

Structure
REQ-026 SHALL take response codes (RESP_OKAY, RESP_SLVERR) and the default width constants from shared package axil_pkg.
REQ-027 SHALL place register storage (byte-strobed write port, one synchronous read port) in sub-module axil_reg_bank.

Verification
REQ-028 Write 0xDEADBEEF to addr 0x04 with strb 0xF, AW one cycle before W -> bvalid one cycle after the W handshake with bresp 00; then read 0x04 -> rdata 0xDEADBEEF, rresp 00.
REQ-029 Write 0x11223344 to 0x08, then write 0xAABBCCDD with strb 0x5 -> read 0x08 returns 0x11BB33DD.
REQ-030 Write to 0x18 (index 6) -> bresp 10, no register changes; read 0x1C -> rdata 0, rresp 10.
REQ-031 Hold bready=0 for 5 cycles after a write -> bvalid, bresp stable; awready and wready stay 0; arready unaffected.
REQ-032 Hold rready=0 for 4 cycles -> rvalid, rdata stable and arready=0; read 0x00 on the same edge a write to 0x00 commits -> old value returned.
REQ-033 Assert reset low with bvalid=1 and rvalid=1 pending -> next cycle bvalid=0, rvalid=0, all registers read back 0.
